// File: rtl/day10_load_counter_pkg.sv
// Shared constants and helpers for the loadable cyclic counter.
package day10_load_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

  // Largest value representable in `width` bits (2^width - 1).
  function automatic int unsigned max_count(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/day10_load_counter_load_base_reg.sv
// Holds the wrap base: captured on load, cleared on reset, otherwise stable.
module load_base_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] base_o
);

  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] base_d;

  always_comb begin
    base_d = base_q;
    if (load_i) begin
      base_d = load_val_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
    end else begin
      base_q <= base_d;
    end
  end

  assign base_o = base_q;

endmodule

// File: rtl/day10_load_counter.sv
// Up-counter with loadable start value; after the all-ones maximum it
// returns to the most recently loaded value instead of zero.
module day10_load_counter
  import day10_load_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(max_count(WIDTH));

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] base_q;

  load_base_reg #(
    .WIDTH (WIDTH)
  ) u_load_base_reg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .base_o     (base_q)
  );

  // Load beats wrap, so a load at the maximum takes the new value.
  always_comb begin
    count_d = count_q + WIDTH'(1);
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q == COUNT_MAX) begin
      count_d = base_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_day10_load_counter.sv
// Directed plus randomized check of day10_load_counter against a
// base/step-count reference model.
module tb_day10_load_counter;
  import day10_load_counter_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  logic         clk;
  logic         reset;
  logic         load_i;
  logic [W-1:0] load_val_i;
  logic [W-1:0] count_o;

  int n_asserts;
  int n_fails;

  // Model: the count is the base plus steps since the last load/reset,
  // folded into the cycle length (2^W - base).
  int m_base;
  int m_steps;

  day10_load_counter #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic count_t model_count();
    int span;
    span = int'(max_count(W)) + 1 - m_base;
    return count_t'(m_base + (m_steps % span));
  endfunction

  task automatic step(input logic r, input logic l, input int v, input string tag);
    count_t exp;
    reset      = r;
    load_i     = l;
    load_val_i = W'(v);
    @(posedge clk);
    if (r) begin
      m_base  = 0;
      m_steps = 0;
    end else if (l) begin
      m_base  = v;
      m_steps = 0;
    end else begin
      m_steps++;
    end
    @(negedge clk);
    exp = model_count();
    n_asserts++;
    assert (count_o === exp) else begin
      n_fails++;
      $error("FAIL %s: count_o observed %0d expected %0d", tag, count_o, exp);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, $urandom_range(0, int'(max_count(W))), tag);
    end
  endtask

  initial begin
    n_asserts  = 0;
    n_fails    = 0;
    m_base     = 0;
    m_steps    = 0;
    reset      = 1'b1;
    load_i     = 1'b0;
    load_val_i = '0;

    // Reset, then free-running modulo count through a wrap to zero
    step(1'b1, 1'b0, 0, "reset_hold");
    step(1'b1, 1'b0, 0, "reset_hold");
    run(20, "plain_count");

    // Load 10: period 6
    step(1'b0, 1'b1, 10, "load10");
    run(14, "count_from10");

    // Load max sticks; then load 3
    step(1'b0, 1'b1, 15, "load15");
    run(22, "stick_at_max");
    step(1'b0, 1'b1, 3, "load3");
    run(16, "count_from3");

    // Held load
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 5, "load5_held");
    run(14, "count_from5");

    // Reset beats load
    step(1'b1, 1'b1, 9, "reset_and_load");
    run(18, "after_reset_load");

    // Reset mid-count discards base
    step(1'b0, 1'b1, 12, "load12");
    run(2, "count_from12");
    step(1'b1, 1'b0, 0, "reset_mid");
    run(17, "after_reset_mid");

    // Every load value 0..14 gives period 16-L
    for (int l = 0; l < 15; l++) begin
      step(1'b0, 1'b1, l, "load_sweep");
      run(17 - l, "sweep_count");
    end

    // Randomized mix of resets, loads and ignored load values
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           $urandom_range(0, int'(max_count(W))), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
